stun_manager: RTL and testbench

STUN_MANAGER -- requirements
Module: stun_manager

---
 rtl/stun_manager_pkg.sv | 32 +++
 rtl/stun_manager_channel.sv | 111 +++++++++++
 rtl/stun_manager.sv | 104 ++++++++++
 tb/tb_stun_manager.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stun_manager_pkg.sv
// Shared game definitions for the stun manager: channel states, player
// indices, hit-count width and the saturating hit-count adder.
package stun_manager_pkg;

    typedef enum logic [1:0] {
        CH_IDLE     = 2'd0,
        CH_STUNNED  = 2'd1,
        CH_CLEARING = 2'd2,
        CH_COOLDOWN = 2'd3
    } chan_state_e;

    localparam int BLUE_VER    = 0;
    localparam int BLUE_HOR    = 1;
    localparam int RED_VER     = 2;
    localparam int RED_HOR     = 3;
    localparam int NUM_PLAYERS = 4;

    localparam int HIT_W = 8;

    // Adds 0..2 new stuns to a team count, pinning at all-ones instead of wrapping.
    function automatic logic [HIT_W-1:0] sat_add_hits(input logic [HIT_W-1:0] cnt,
                                                      input logic [1:0]       inc);
        logic [HIT_W:0] sum;
        sum = {1'b0, cnt} + {{(HIT_W-1){1'b0}}, inc};
        if (sum[HIT_W]) begin
            sat_add_hits = {HIT_W{1'b1}};
        end else begin
            sat_add_hits = sum[HIT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/stun_manager_channel.sv
// One player's stun channel: IDLE -> STUNNED -> CLEARING -> COOLDOWN with a
// tick-driven down counter; frozen/clean are registered from the next state.
module stun_channel
    import stun_manager_pkg::*;
#(
    parameter int STUN_TICKS     = 120,
    parameter int COOLDOWN_TICKS = 60,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic enable,
    input  logic bludged,
    output logic clean,
    output logic frozen,
    output logic hit_pulse
);

    localparam logic [CNT_W-1:0] STUN_LOAD = CNT_W'(STUN_TICKS);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             COOL_ZERO = 1'(COOLDOWN_TICKS == 0);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frozen_q, frozen_d;
    logic             clean_q, clean_d;

    // Next-state, counter and output decode for the channel.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hit_pulse = 1'b0;
        if (!enable) begin
            state_d = CH_IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                CH_IDLE: begin
                    // Freshly loaded counter is never decremented on the entry edge.
                    if (bludged) begin
                        state_d   = CH_STUNNED;
                        cnt_d     = STUN_LOAD;
                        hit_pulse = 1'b1;
                    end else begin
                        state_d = CH_IDLE;
                    end
                end
                CH_STUNNED: begin
                    if (tick && (cnt_q <= CNT_ONE)) begin
                        state_d = CH_CLEARING;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                CH_CLEARING: begin
                    if (!bludged) begin
                        state_d = CH_COOLDOWN;
                        cnt_d   = COOL_LOAD;
                    end else begin
                        state_d = CH_CLEARING;
                    end
                end
                CH_COOLDOWN: begin
                    if (COOL_ZERO || (tick && (cnt_q <= CNT_ONE))) begin
                        state_d = CH_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = CH_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
        frozen_d = (state_d == CH_STUNNED) || (state_d == CH_CLEARING);
        // A disable during CLEARING still owes the bludger stage one clean cycle.
        if (enable) begin
            clean_d = (state_d == CH_CLEARING);
        end else begin
            clean_d = (state_q == CH_CLEARING);
        end
    end

    // Channel state, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CH_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            frozen_q <= 1'b0;
            clean_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frozen_q <= frozen_d;
            clean_q  <= clean_d;
        end
    end

    assign frozen = frozen_q;
    assign clean  = clean_q;

endmodule

// File: rtl/stun_manager.sv
// Stun manager top: game-tick divider, four stun channels and the per-team
// saturating hit counters.
module stun_manager
    import stun_manager_pkg::*;
#(
    parameter int TICK_DIVIDER   = 500000,
    parameter int STUN_TICKS     = 120,
    parameter int COOLDOWN_TICKS = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             game_initiated,
    input  logic             blue_ver_bludged,
    input  logic             blue_hor_bludged,
    input  logic             red_ver_bludged,
    input  logic             red_hor_bludged,
    output logic             blue_ver_clean,
    output logic             blue_hor_clean,
    output logic             red_ver_clean,
    output logic             red_hor_clean,
    output logic             blue_ver_frozen,
    output logic             blue_hor_frozen,
    output logic             red_ver_frozen,
    output logic             red_hor_frozen,
    output logic [HIT_W-1:0] blue_hits,
    output logic [HIT_W-1:0] red_hits,
    output logic             tick
);

    localparam int MAX_TICKS = (STUN_TICKS > COOLDOWN_TICKS) ? STUN_TICKS : COOLDOWN_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 0) ? $clog2(MAX_TICKS + 1) : 1;
    localparam int DIV_W     = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIVIDER - 1);

    logic [DIV_W-1:0]       div_q, div_d;
    logic                   tick_q, tick_d;
    logic [HIT_W-1:0]       blue_hits_q, blue_hits_d;
    logic [HIT_W-1:0]       red_hits_q, red_hits_d;
    logic [NUM_PLAYERS-1:0] bludged_s, clean_s, frozen_s, hit_s;

    assign bludged_s[BLUE_VER] = blue_ver_bludged;
    assign bludged_s[BLUE_HOR] = blue_hor_bludged;
    assign bludged_s[RED_VER]  = red_ver_bludged;
    assign bludged_s[RED_HOR]  = red_hor_bludged;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
        stun_channel #(
            .STUN_TICKS     (STUN_TICKS),
            .COOLDOWN_TICKS (COOLDOWN_TICKS),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick_q),
            .enable    (game_initiated),
            .bludged   (bludged_s[p]),
            .clean     (clean_s[p]),
            .frozen    (frozen_s[p]),
            .hit_pulse (hit_s[p])
        );
    end

    // Tick divider and team hit counters; tick is registered from the next count.
    always_comb begin
        if (div_q == DIV_LAST) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        tick_d      = (div_d == DIV_LAST);
        blue_hits_d = sat_add_hits(blue_hits_q,
                                   {1'b0, hit_s[BLUE_VER]} + {1'b0, hit_s[BLUE_HOR]});
        red_hits_d  = sat_add_hits(red_hits_q,
                                   {1'b0, hit_s[RED_VER]} + {1'b0, hit_s[RED_HOR]});
    end

    // Divider, tick strobe and hit count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= {DIV_W{1'b0}};
            tick_q      <= 1'b0;
            blue_hits_q <= {HIT_W{1'b0}};
            red_hits_q  <= {HIT_W{1'b0}};
        end else begin
            div_q       <= div_d;
            tick_q      <= tick_d;
            blue_hits_q <= blue_hits_d;
            red_hits_q  <= red_hits_d;
        end
    end

    assign tick            = tick_q;
    assign blue_hits       = blue_hits_q;
    assign red_hits        = red_hits_q;
    assign blue_ver_clean  = clean_s[BLUE_VER];
    assign blue_hor_clean  = clean_s[BLUE_HOR];
    assign red_ver_clean   = clean_s[RED_VER];
    assign red_hor_clean   = clean_s[RED_HOR];
    assign blue_ver_frozen = frozen_s[BLUE_VER];
    assign blue_hor_frozen = frozen_s[BLUE_HOR];
    assign red_ver_frozen  = frozen_s[RED_VER];
    assign red_hor_frozen  = frozen_s[RED_HOR];

endmodule

// File: tb/tb_stun_manager.sv
// Directed bench for stun_manager with TICK_DIVIDER=4, STUN_TICKS=3, COOLDOWN_TICKS=2.
module tb_stun_manager;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_initiated;
    logic       bv_b, bh_b, rv_b, rh_b;
    logic       bv_c, bh_c, rv_c, rh_c;
    logic       bv_f, bh_f, rv_f, rh_f;
    logic [7:0] blue_hits, red_hits;
    logic       tick;

    int checks = 0;
    int errors = 0;

    stun_manager #(
        .TICK_DIVIDER   (4),
        .STUN_TICKS     (3),
        .COOLDOWN_TICKS (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .game_initiated   (game_initiated),
        .blue_ver_bludged (bv_b),
        .blue_hor_bludged (bh_b),
        .red_ver_bludged  (rv_b),
        .red_hor_bludged  (rh_b),
        .blue_ver_clean   (bv_c),
        .blue_hor_clean   (bh_c),
        .red_ver_clean    (rv_c),
        .red_hor_clean    (rh_c),
        .blue_ver_frozen  (bv_f),
        .blue_hor_frozen  (bh_f),
        .red_ver_frozen   (rv_f),
        .red_hor_frozen   (rh_f),
        .blue_hits        (blue_hits),
        .red_hits         (red_hits),
        .tick             (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic bv;
        logic exp_tick;
        logic exp_frozen;
        logic exp_clean;
        int   exp_bhits;
    } vec_t;

    vec_t tbl[25];

    function automatic logic [3:0] frozen_v();
        return {rh_f, rv_f, bh_f, bv_f};
    endfunction

    function automatic logic [3:0] clean_v();
        return {rh_c, rv_c, bh_c, bv_c};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Rows are edge numbers 1..25 after reset release.
    task automatic set_rows(input int first, input int last, input logic bv,
                            input logic fr, input logic cl, input int bh);
        for (int n = first; n <= last; n++) begin
            tbl[n-1].bv         = bv;
            tbl[n-1].exp_tick   = ((n % 4) == 3);
            tbl[n-1].exp_frozen = fr;
            tbl[n-1].exp_clean  = cl;
            tbl[n-1].exp_bhits  = bh;
        end
    endtask

    task automatic wait_for(input logic [3:0] mask, input logic use_clean, input string nm);
        int n;
        logic [3:0] v;
        n = 0;
        v = use_clean ? clean_v() : frozen_v();
        while (((v & mask) != mask) && (n < 60)) begin
            step();
            n++;
            v = use_clean ? clean_v() : frozen_v();
        end
        chk(nm, int'((v & mask) == mask), 1);
    endtask

    initial begin
        // Blue-vertical stun entering on a tick edge, clean, cooldown re-hit, restart.
        set_rows(1, 3, 1'b0, 1'b0, 1'b0, 0);
        set_rows(4, 15, 1'b1, 1'b1, 1'b0, 1);
        set_rows(16, 16, 1'b1, 1'b1, 1'b1, 1);
        set_rows(17, 18, 1'b0, 1'b0, 1'b0, 1);
        set_rows(19, 24, 1'b1, 1'b0, 1'b0, 1);
        set_rows(25, 25, 1'b1, 1'b1, 1'b0, 2);

        rst = 1'b1;
        game_initiated = 1'b1;
        bv_b = 1'b0; bh_b = 1'b0; rv_b = 1'b0; rh_b = 1'b0;
        step();
        step();
        chk("rst_frozen", int'(frozen_v()), 0);
        chk("rst_clean", int'(clean_v()), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_bhits", int'(blue_hits), 0);
        chk("rst_rhits", int'(red_hits), 0);
        rst = 1'b0;

        for (int k = 0; k < 25; k++) begin
            bv_b = tbl[k].bv;
            step();
            chk($sformatf("tbl%0d_tick", k + 1), int'(tick), int'(tbl[k].exp_tick));
            chk($sformatf("tbl%0d_frozen", k + 1), int'(frozen_v()), int'({3'b000, tbl[k].exp_frozen}));
            chk($sformatf("tbl%0d_clean", k + 1), int'(clean_v()), int'({3'b000, tbl[k].exp_clean}));
            chk($sformatf("tbl%0d_bhits", k + 1), int'(blue_hits), tbl[k].exp_bhits);
            chk($sformatf("tbl%0d_rhits", k + 1), int'(red_hits), 0);
        end

        // Asynchronous reset while blue-vertical is stunned.
        #2;
        rst = 1'b1;
        bv_b = 1'b0;
        #1;
        chk("arst_frozen", int'(frozen_v()), 0);
        chk("arst_clean", int'(clean_v()), 0);
        chk("arst_bhits", int'(blue_hits), 0);
        chk("arst_tick", int'(tick), 0);
        step();
        rst = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk($sformatf("arst_tick%0d", n), int'(tick), int'(n == 3));
            chk($sformatf("arst_noclean%0d", n), int'(clean_v()), 0);
            chk($sformatf("arst_nofrozen%0d", n), int'(frozen_v()), 0);
        end

        // Simultaneous red hits, with red_hor's flag dropped one cycle late.
        rv_b = 1'b1; rh_b = 1'b1;
        step();
        chk("pair_rhits", int'(red_hits), 2);
        chk("pair_frozen", int'(frozen_v()), int'(4'b1100));
        wait_for(4'b0100, 1'b1, "pair_rv_clean_seen");
        chk("pair_both_clean", int'(clean_v()), int'(4'b1100));
        rv_b = 1'b0;
        step();
        chk("pair_split_frozen", int'(frozen_v()), int'(4'b1000));
        chk("pair_split_clean", int'(clean_v()), int'(4'b1000));
        rh_b = 1'b0;
        step();
        chk("pair_done_frozen", int'(frozen_v()), 0);
        chk("pair_done_clean", int'(clean_v()), 0);
        chk("pair_done_rhits", int'(red_hits), 2);

        // Flags are re-raised during cooldown so each pair restarts at cooldown end.
        for (int i = 0; i < 126; i++) begin
            rv_b = 1'b1; rh_b = 1'b1;
            wait_for(4'b1100, 1'b1, $sformatf("loop%0d_clean", i));
            rv_b = 1'b0; rh_b = 1'b0;
            step();
        end
        chk("sat_254", int'(red_hits), 254);
        rv_b = 1'b1; rh_b = 1'b1;
        wait_for(4'b1100, 1'b1, "sat_pair_clean");
        chk("sat_255", int'(red_hits), 255);
        rv_b = 1'b0; rh_b = 1'b0;
        step();
        rv_b = 1'b1;
        wait_for(4'b0100, 1'b1, "sat_single_clean");
        chk("sat_hold_255", int'(red_hits), 255);
        rv_b = 1'b0;
        step();

        // game_initiated dropped while stunned, then while clearing.
        rv_b = 1'b1;
        wait_for(4'b0100, 1'b0, "gi_stun_frozen");
        game_initiated = 1'b0;
        step();
        chk("gi_stun_frozen0", int'(frozen_v()), 0);
        chk("gi_stun_clean0", int'(clean_v()), 0);
        step();
        chk("gi_disabled_frozen", int'(frozen_v()), 0);
        game_initiated = 1'b1;
        step();
        chk("gi_restart_frozen", int'(frozen_v()), int'(4'b0100));
        wait_for(4'b0100, 1'b1, "gi_clear_seen");
        game_initiated = 1'b0;
        step();
        chk("gi_clear_clean1", int'(clean_v()), int'(4'b0100));
        chk("gi_clear_frozen0", int'(frozen_v()), 0);
        step();
        chk("gi_clear_clean0", int'(clean_v()), 0);
        chk("gi_clear_idle_frozen", int'(frozen_v()), 0);
        rv_b = 1'b0;
        game_initiated = 1'b1;
        chk("final_rhits", int'(red_hits), 255);
        chk("final_bhits", int'(blue_hits), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
